// File: rtl/branch_resolve_queue_pkg.sv
// Shared types for the branch resolve queue and the predictor commit-update path.
`ifndef BRQ_DEFINES_SVH
`define BRQ_DEFINES_SVH
`define BTB_BITS     10
`define BRQ_DEPTH    8
`define BRQ_TAG_BITS 3
`endif

package branch_resolve_queue_pkg;

  // Storage width of PC/target fields; modules narrower than this zero-pad.
  localparam int BRQ_ADDR_W = 64;

  // One in-flight branch.
  typedef struct packed {
    logic                  valid;
    logic                  resolved;
    logic [BRQ_ADDR_W-1:0] pc;
    logic                  pred_taken;
    logic [BRQ_ADDR_W-1:0] pred_target;
    logic                  taken;
    logic [BRQ_ADDR_W-1:0] target;
  } BRQ_ENTRY;

  // Commit-update record consumed by the BTB / local-history tables.
  typedef struct packed {
    logic                  committed_is_branch;
    logic                  branch_taken;
    logic [BRQ_ADDR_W-1:0] branch_pc;
    logic [BRQ_ADDR_W-1:0] branch_target;
  } ROB_PRED;

endpackage

// File: rtl/branch_resolve_queue_commit_check.sv
// Per-slot commit comparator: mispredict flag and the architecturally correct next PC.
module brq_commit_check
  import branch_resolve_queue_pkg::*;
#(
  parameter int ADDR_BITS = BRQ_ADDR_W
) (
  input  logic [ADDR_BITS-1:0] pc,
  input  logic                 pred_taken,
  input  logic [ADDR_BITS-1:0] pred_target,
  input  logic                 taken,
  input  logic [ADDR_BITS-1:0] target,
  output logic                 mispredict,
  output logic [ADDR_BITS-1:0] branch_target
);

  // Target only matters when the branch was actually taken; fall-through wraps.
  always_comb begin
    mispredict    = (pred_taken != taken) || (taken && (pred_target != target));
    branch_target = taken ? target : pc + ADDR_BITS'(4);
  end

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order circular queue of in-flight branches: 2-wide dispatch, 1 out-of-order
// resolve per cycle, 2-wide in-order commit with a registered predictor update stream.
module branch_resolve_queue
  import branch_resolve_queue_pkg::*;
#(
  parameter int BRQ_DEPTH = `BRQ_DEPTH,
  parameter int ADDR_BITS = BRQ_ADDR_W,
  parameter int TAG_BITS  = `BRQ_TAG_BITS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 alloc_valid_0,
  input  logic                 alloc_valid_1,
  input  logic [ADDR_BITS-1:0] alloc_pc_0,
  input  logic [ADDR_BITS-1:0] alloc_pc_1,
  input  logic                 alloc_pred_taken_0,
  input  logic                 alloc_pred_taken_1,
  input  logic [ADDR_BITS-1:0] alloc_pred_target_0,
  input  logic [ADDR_BITS-1:0] alloc_pred_target_1,
  output logic [TAG_BITS-1:0]  alloc_tag_0,
  output logic [TAG_BITS-1:0]  alloc_tag_1,
  output logic [TAG_BITS:0]    free_count,
  input  logic                 res_valid,
  input  logic [TAG_BITS-1:0]  res_tag,
  input  logic                 res_taken,
  input  logic [ADDR_BITS-1:0] res_target,
  output logic                 head_resolved_0,
  output logic                 head_resolved_1,
  input  logic                 commit_0,
  input  logic                 commit_1,
  input  logic                 flush,
  output logic                 committed_is_branch_0,
  output logic                 committed_is_branch_1,
  output logic                 branch_taken_0,
  output logic                 branch_taken_1,
  output logic [ADDR_BITS-1:0] branch_pc_ROB_0,
  output logic [ADDR_BITS-1:0] branch_pc_ROB_1,
  output logic [ADDR_BITS-1:0] branch_target_0,
  output logic [ADDR_BITS-1:0] branch_target_1,
  output logic                 mispredict_0,
  output logic                 mispredict_1
);

  BRQ_ENTRY [BRQ_DEPTH-1:0] q;
  logic [TAG_BITS-1:0]      head, tail;
  logic [TAG_BITS:0]        count;

  BRQ_ENTRY [1:0]           new_entry;
  logic [1:0]               acc;        // dispatch slot accepted
  logic [1:0]               cmt;        // commit slot accepted

  // Per commit slot: slot 0 looks at head, slot 1 at head+1.
  logic [1:0][TAG_BITS-1:0]  slot_idx;
  logic [1:0]                slot_hr;
  logic [1:0]                slot_taken;
  logic [1:0][ADDR_BITS-1:0] slot_pc;
  logic [1:0]                slot_mis;
  logic [1:0][ADDR_BITS-1:0] slot_tgt;

  ROB_PRED [1:0]            upd;
  logic [1:0]               mis_q;

  // Allocation tags and acceptance; free space never credits same-cycle commits.
  always_comb begin
    free_count  = (TAG_BITS+1)'(BRQ_DEPTH) - count;
    alloc_tag_0 = tail;
    alloc_tag_1 = alloc_valid_0 ? tail + TAG_BITS'(1) : tail;
    acc[0]      = alloc_valid_0 && (free_count != '0);
    acc[1]      = alloc_valid_1 &&
                  (acc[0] ? (free_count >= (TAG_BITS+1)'(2)) : (free_count != '0));
  end

  // Fresh entries as written by dispatch: valid, not yet resolved.
  always_comb begin
    new_entry                = '0;
    new_entry[0].valid       = 1'b1;
    new_entry[0].pc          = BRQ_ADDR_W'(alloc_pc_0);
    new_entry[0].pred_taken  = alloc_pred_taken_0;
    new_entry[0].pred_target = BRQ_ADDR_W'(alloc_pred_target_0);
    new_entry[1].valid       = 1'b1;
    new_entry[1].pc          = BRQ_ADDR_W'(alloc_pc_1);
    new_entry[1].pred_taken  = alloc_pred_taken_1;
    new_entry[1].pred_target = BRQ_ADDR_W'(alloc_pred_target_1);
  end

  assign slot_idx[0] = head;
  assign slot_idx[1] = head + TAG_BITS'(1);

  for (genvar g = 0; g < 2; g++) begin : g_slot
    BRQ_ENTRY e;
    assign e             = q[slot_idx[g]];
    assign slot_hr[g]    = e.valid & e.resolved;
    assign slot_taken[g] = e.taken;
    assign slot_pc[g]    = e.pc[ADDR_BITS-1:0];

    brq_commit_check #(.ADDR_BITS(ADDR_BITS)) u_chk (
      .pc            (e.pc[ADDR_BITS-1:0]),
      .pred_taken    (e.pred_taken),
      .pred_target   (e.pred_target[ADDR_BITS-1:0]),
      .taken         (e.taken),
      .target        (e.target[ADDR_BITS-1:0]),
      .mispredict    (slot_mis[g]),
      .branch_target (slot_tgt[g])
    );
  end

  // Head readiness comes from registered state only; slot 1 cannot commit without slot 0.
  always_comb begin
    head_resolved_0 = slot_hr[0];
    head_resolved_1 = slot_hr[1];
    cmt[0]          = commit_0 && slot_hr[0];
    cmt[1]          = cmt[0] && commit_1 && slot_hr[1];
  end

  // Queue state: flush wipes everything, otherwise resolve, retire, then dispatch.
  always_ff @(posedge clock) begin
    if (reset) begin
      q     <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      q     <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (res_valid && q[res_tag].valid) begin
        q[res_tag].resolved <= 1'b1;
        q[res_tag].taken    <= res_taken;
        q[res_tag].target   <= BRQ_ADDR_W'(res_target);
      end
      for (int s = 0; s < 2; s++) begin
        if (cmt[s]) begin
          q[slot_idx[s]].valid    <= 1'b0;
          q[slot_idx[s]].resolved <= 1'b0;
        end
      end
      // Dispatch never targets a slot freed this cycle, so these writes cannot collide.
      if (acc[0]) q[alloc_tag_0] <= new_entry[0];
      if (acc[1]) q[alloc_tag_1] <= new_entry[1];
      head  <= head + TAG_BITS'(cmt[0]) + TAG_BITS'(cmt[1]);
      tail  <= tail + TAG_BITS'(acc[0]) + TAG_BITS'(acc[1]);
      count <= count + (TAG_BITS+1)'(acc[0]) + (TAG_BITS+1)'(acc[1])
                     - (TAG_BITS+1)'(cmt[0]) - (TAG_BITS+1)'(cmt[1]);
    end
  end

  // Registered commit updates: valid pulses for one cycle, data holds until the next commit.
  // A same-cycle flush still lets the retiring branches report.
  always_ff @(posedge clock) begin
    if (reset) begin
      upd   <= '0;
      mis_q <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        upd[s].committed_is_branch <= cmt[s];
        if (cmt[s]) begin
          upd[s].branch_taken  <= slot_taken[s];
          upd[s].branch_pc     <= BRQ_ADDR_W'(slot_pc[s]);
          upd[s].branch_target <= BRQ_ADDR_W'(slot_tgt[s]);
          mis_q[s]             <= slot_mis[s];
        end
      end
    end
  end

  assign committed_is_branch_0 = upd[0].committed_is_branch;
  assign committed_is_branch_1 = upd[1].committed_is_branch;
  assign branch_taken_0        = upd[0].branch_taken;
  assign branch_taken_1        = upd[1].branch_taken;
  assign branch_pc_ROB_0       = upd[0].branch_pc[ADDR_BITS-1:0];
  assign branch_pc_ROB_1       = upd[1].branch_pc[ADDR_BITS-1:0];
  assign branch_target_0       = upd[0].branch_target[ADDR_BITS-1:0];
  assign branch_target_1       = upd[1].branch_target[ADDR_BITS-1:0];
  assign mispredict_0          = mis_q[0];
  assign mispredict_1          = mis_q[1];

endmodule
